// File: rtl/seq_ctrl_pkg.sv
// Shared encodings for the sequential RV64 control unit:
// opcodes, ALU codes, FSM states and instruction op classes.
package seq_ctrl_pkg;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_SD   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_DW  = 3'b011;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      CL_R,
      CL_IALU,
      CL_LD,
      CL_SD,
      CL_BEQ
   } op_class_t;

   // Classes whose ALU B operand is the immediate rather than rs2.
   function automatic logic uses_imm(op_class_t c);
      return (c == CL_IALU) || (c == CL_LD) || (c == CL_SD);
   endfunction

endpackage

// File: rtl/seq_ctrl_fsm_if.sv
// Datapath/memory handshake bundle between the control unit
// (master) and the datapath plus memories (slave).
interface seq_ctrl_fsm_if;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5;
   logic       zero;
   logic       imem_ready;
   logic       dmem_ready;

   logic       imem_req;
   logic       ir_write;
   logic       pc_write;
   logic       pc_src;
   logic       dmem_read;
   logic       dmem_write;
   logic       reg_write;
   logic       mem_to_reg;
   logic       alu_src_b;
   logic [3:0] alu_control;

   modport master (
      input  opcode, funct3, funct7_5, zero,
      input  imem_ready, dmem_ready,
      output imem_req, ir_write, pc_write, pc_src,
      output dmem_read, dmem_write, reg_write, mem_to_reg,
      output alu_src_b, alu_control
   );

   modport slave (
      output opcode, funct3, funct7_5, zero,
      output imem_ready, dmem_ready,
      input  imem_req, ir_write, pc_write, pc_src,
      input  dmem_read, dmem_write, reg_write, mem_to_reg,
      input  alu_src_b, alu_control
   );

endinterface

// File: rtl/seq_ctrl_fsm_alu_ctrl_decode.sv
// Combinational instruction classifier: maps opcode/funct fields
// to the ALU operation, op class and a legality flag.
module alu_ctrl_decode
   import seq_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [3:0] alu_control,
   output op_class_t  op_class,
   output logic       legal
);

   always_comb begin
      alu_control = ALU_ADD;
      op_class    = CL_R;
      legal       = 1'b0;
      case (opcode)
         OP_R: begin
            op_class = CL_R;
            case ({funct7_5, funct3})
               {1'b0, F3_ADD}: begin
                  alu_control = ALU_ADD;
                  legal       = 1'b1;
               end
               {1'b1, F3_ADD}: begin
                  alu_control = ALU_SUB;
                  legal       = 1'b1;
               end
               {1'b0, F3_AND}: begin
                  alu_control = ALU_AND;
                  legal       = 1'b1;
               end
               {1'b0, F3_OR}: begin
                  alu_control = ALU_OR;
                  legal       = 1'b1;
               end
               {1'b0, F3_SLT}: begin
                  alu_control = ALU_SLT;
                  legal       = 1'b1;
               end
               default: legal = 1'b0;
            endcase
         end
         // IR[30] is immediate data here, so it plays no part.
         OP_IALU: begin
            op_class = CL_IALU;
            case (funct3)
               F3_ADD: begin
                  alu_control = ALU_ADD;
                  legal       = 1'b1;
               end
               F3_AND: begin
                  alu_control = ALU_AND;
                  legal       = 1'b1;
               end
               F3_OR: begin
                  alu_control = ALU_OR;
                  legal       = 1'b1;
               end
               F3_SLT: begin
                  alu_control = ALU_SLT;
                  legal       = 1'b1;
               end
               default: legal = 1'b0;
            endcase
         end
         OP_LD: begin
            op_class    = CL_LD;
            alu_control = ALU_ADD;
            legal       = (funct3 == F3_DW);
         end
         OP_SD: begin
            op_class    = CL_SD;
            alu_control = ALU_ADD;
            legal       = (funct3 == F3_DW);
         end
         OP_BEQ: begin
            op_class    = CL_BEQ;
            alu_control = ALU_SUB;
            legal       = (funct3 == F3_ADD);
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seq_ctrl_fsm.sv
// Multi-cycle control FSM for the sequential RV64 core: sequences
// fetch/decode/exec/mem/wb and drives the shared ALU and strobes.
module seq_ctrl_fsm
   import seq_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   seq_ctrl_fsm_if.master   bus,
   output logic             illegal,
   output logic [2:0]       state_dbg,
   output logic [CNT_W-1:0] retired
);

   state_t     state;
   state_t     state_nx;
   op_class_t  cls_q;
   op_class_t  dec_cls;
   logic [3:0] alu_q;
   logic [3:0] dec_alu;
   logic       dec_legal;
   logic       retire;

   alu_ctrl_decode u_dec (
      .opcode      (bus.opcode),
      .funct3      (bus.funct3),
      .funct7_5    (bus.funct7_5),
      .alu_control (dec_alu),
      .op_class    (dec_cls),
      .legal       (dec_legal)
   );

   // Class and ALU op are captured once so later IR changes are inert.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         cls_q   <= CL_R;
         alu_q   <= ALU_ADD;
         illegal <= 1'b0;
         retired <= '0;
      end else begin
         state <= state_nx;
         if (state == S_DECODE) begin
            cls_q <= dec_cls;
            alu_q <= dec_alu;
            if (!dec_legal)
               illegal <= 1'b1;
         end
         if (retire)
            retired <= retired + CNT_W'(1);
      end
   end

   always_comb begin
      state_nx        = state;
      retire          = 1'b0;
      bus.imem_req    = 1'b0;
      bus.ir_write    = 1'b0;
      bus.pc_write    = 1'b0;
      bus.pc_src      = 1'b0;
      bus.dmem_read   = 1'b0;
      bus.dmem_write  = 1'b0;
      bus.reg_write   = 1'b0;
      bus.mem_to_reg  = 1'b0;
      bus.alu_src_b   = 1'b0;
      bus.alu_control = alu_q;
      unique case (state)
         S_IDLE: state_nx = S_FETCH;
         S_FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ready) begin
               bus.ir_write = 1'b1;
               bus.pc_write = 1'b1;
               state_nx     = S_DECODE;
            end
         end
         S_DECODE: begin
            bus.alu_control = dec_alu;
            bus.alu_src_b   = dec_legal && uses_imm(dec_cls);
            state_nx        = dec_legal ? S_EXEC : S_HALT;
         end
         S_EXEC: begin
            bus.alu_src_b = uses_imm(cls_q);
            case (cls_q)
               CL_BEQ: begin
                  bus.pc_write = bus.zero;
                  bus.pc_src   = bus.zero;
                  retire       = 1'b1;
                  state_nx     = S_FETCH;
               end
               CL_LD, CL_SD: state_nx = S_MEM;
               default:      state_nx = S_WB;
            endcase
         end
         S_MEM: begin
            bus.alu_src_b = uses_imm(cls_q);
            if (cls_q == CL_LD) begin
               bus.dmem_read = 1'b1;
               if (bus.dmem_ready)
                  state_nx = S_WB;
            end else begin
               bus.dmem_write = 1'b1;
               if (bus.dmem_ready) begin
                  retire   = 1'b1;
                  state_nx = S_FETCH;
               end
            end
         end
         S_WB: begin
            bus.alu_src_b  = uses_imm(cls_q);
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = (cls_q == CL_LD);
            retire         = 1'b1;
            state_nx       = S_FETCH;
         end
         S_HALT: state_nx = S_HALT;
         default: state_nx = S_IDLE;
      endcase
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_seq_ctrl_fsm.sv
// Randomized bench for seq_ctrl_fsm against a per-instruction
// cycle-trace model built from the instruction's phase sequence.
module tb_seq_ctrl_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic        illegal;
   logic [2:0]  state_dbg;
   logic [31:0] retired;

   seq_ctrl_fsm_if bus ();

   seq_ctrl_fsm #(.CNT_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .illegal   (illegal),
      .state_dbg (state_dbg),
      .retired   (retired)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_ret = '0;
   logic        exp_ill = 1'b0;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] strobes();
      return {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src,
              bus.dmem_read, bus.dmem_write, bus.reg_write, bus.mem_to_reg};
   endfunction

   // One clock: drive inputs at negedge, check outputs 1ns later.
   task automatic cyc(string tag, bit ir, bit dr, bit z,
                      logic [7:0] es, logic [2:0] est,
                      bit ck_alu, logic [3:0] ea, bit eb);
      @(negedge clk);
      bus.imem_ready = ir;
      bus.dmem_ready = dr;
      bus.zero       = z;
      #1;
      check({tag, "_strobes"}, 64'(strobes()), 64'(es));
      check({tag, "_state"}, 64'(state_dbg), 64'(est));
      check({tag, "_retired"}, 64'(retired), 64'(exp_ret));
      check({tag, "_illegal"}, 64'(illegal), 64'(exp_ill));
      if (ck_alu) begin
         check({tag, "_alu"}, 64'(bus.alu_control), 64'(ea));
         check({tag, "_srcb"}, 64'(bus.alu_src_b), 64'(eb));
      end
   endtask

   task automatic scramble_ir();
      bus.opcode   = 7'($urandom);
      bus.funct3   = 3'($urandom);
      bus.funct7_5 = 1'($urandom);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b1;
      exp_ret = '0;
      exp_ill = 1'b0;
      #1;
      check("rst_strobes", 64'(strobes()), 64'(0));
      check("rst_state", 64'(state_dbg), 64'(0));
      check("rst_alu", 64'(bus.alu_control), 64'(4'b0010));
      check("rst_retired", 64'(retired), 64'(0));
      check("rst_illegal", 64'(illegal), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("idle_state", 64'(state_dbg), 64'(0));
      check("idle_strobes", 64'(strobes()), 64'(0));
   endtask

   // k: 0-4 R add/sub/and/or/slt, 5-8 I add/and/or/slt, 9 ld, 10 sd, 11 beq
   task automatic run_instr(int k, int wi, int wd, bit z);
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic [3:0] ea;
      int         cls;
      bit         imm;
      f7 = 1'b0;
      case (k)
         0: begin op = 7'b0110011; f3 = 3'b000; ea = 4'b0010; cls = 0; end
         1: begin op = 7'b0110011; f3 = 3'b000; ea = 4'b0110; cls = 0; f7 = 1'b1; end
         2: begin op = 7'b0110011; f3 = 3'b111; ea = 4'b0000; cls = 0; end
         3: begin op = 7'b0110011; f3 = 3'b110; ea = 4'b0001; cls = 0; end
         4: begin op = 7'b0110011; f3 = 3'b010; ea = 4'b0111; cls = 0; end
         5: begin op = 7'b0010011; f3 = 3'b000; ea = 4'b0010; cls = 1; end
         6: begin op = 7'b0010011; f3 = 3'b111; ea = 4'b0000; cls = 1; end
         7: begin op = 7'b0010011; f3 = 3'b110; ea = 4'b0001; cls = 1; end
         8: begin op = 7'b0010011; f3 = 3'b010; ea = 4'b0111; cls = 1; end
         9: begin op = 7'b0000011; f3 = 3'b011; ea = 4'b0010; cls = 2; end
         10: begin op = 7'b0100011; f3 = 3'b011; ea = 4'b0010; cls = 3; end
         default: begin op = 7'b1100011; f3 = 3'b000; ea = 4'b0110; cls = 4; end
      endcase
      if (cls == 1)
         f7 = 1'($urandom);
      imm = (cls == 1) || (cls == 2) || (cls == 3);
      bus.opcode   = op;
      bus.funct3   = f3;
      bus.funct7_5 = f7;
      for (int i = 0; i < wi; i++)
         cyc("fetch_wait", 1'b0, 1'($urandom), 1'($urandom),
             8'h80, 3'd1, 1'b0, 4'h0, 1'b0);
      cyc("fetch", 1'b1, 1'b0, 1'b0, 8'hE0, 3'd1, 1'b0, 4'h0, 1'b0);
      cyc("decode", 1'b0, 1'($urandom), 1'b0, 8'h00, 3'd2, 1'b0, 4'h0, 1'b0);
      @(posedge clk);
      #1;
      scramble_ir();
      if (cls == 4) begin
         cyc("exec_beq", 1'b0, 1'b0, z, z ? 8'h30 : 8'h00, 3'd3, 1'b1, ea, 1'b0);
         exp_ret++;
         return;
      end
      cyc("exec", 1'($urandom), 1'($urandom), 1'($urandom),
          8'h00, 3'd3, 1'b1, ea, imm);
      if (cls == 2 || cls == 3) begin
         for (int i = 0; i <= wd; i++)
            cyc(cls == 2 ? "mem_ld" : "mem_sd", 1'($urandom), i == wd, 1'b0,
                cls == 2 ? 8'h08 : 8'h04, 3'd4, 1'b1, ea, 1'b1);
         if (cls == 3) begin
            exp_ret++;
            return;
         end
      end
      cyc("wb", 1'($urandom), 1'b0, 1'b0, cls == 2 ? 8'h03 : 8'h02,
          3'd5, 1'b1, ea, imm);
      exp_ret++;
   endtask

   task automatic run_illegal(logic [6:0] op, logic [2:0] f3, logic f7);
      bus.opcode   = op;
      bus.funct3   = f3;
      bus.funct7_5 = f7;
      cyc("ill_fetch", 1'b1, 1'b0, 1'b0, 8'hE0, 3'd1, 1'b0, 4'h0, 1'b0);
      cyc("ill_decode", 1'b0, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0, 4'h0, 1'b0);
      exp_ill = 1'b1;
      for (int i = 0; i < 5; i++)
         cyc("halt", 1'b1, 1'b1, 1'b1, 8'h00, 3'd6, 1'b0, 4'h0, 1'b0);
      do_reset();
   endtask

   initial begin
      reset          = 1'b1;
      bus.opcode     = '0;
      bus.funct3     = '0;
      bus.funct7_5   = 1'b0;
      bus.zero       = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      repeat (2) @(negedge clk);
      do_reset();

      run_instr(0, 0, 0, 1'b0);
      for (int k = 1; k <= 4; k++)
         run_instr(k, 0, 0, 1'b0);
      run_instr(9, 0, 3, 1'b0);
      run_instr(11, 0, 0, 1'b1);
      run_instr(11, 0, 0, 1'b0);
      run_instr(10, 1, 2, 1'b0);

      for (int n = 0; n < 150; n++)
         run_instr($urandom_range(0, 11), $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom));

      run_illegal(7'b1111111, 3'b000, 1'b0);
      run_illegal(7'b0110011, 3'b111, 1'b1);

      run_instr(10, 0, 0, 1'b0);
      bus.opcode   = 7'b0100011;
      bus.funct3   = 3'b011;
      bus.funct7_5 = 1'b0;
      cyc("sdr_fetch", 1'b1, 1'b0, 1'b0, 8'hE0, 3'd1, 1'b0, 4'h0, 1'b0);
      cyc("sdr_decode", 1'b0, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0, 4'h0, 1'b0);
      cyc("sdr_exec", 1'b0, 1'b0, 1'b0, 8'h00, 3'd3, 1'b1, 4'b0010, 1'b1);
      cyc("sdr_mem", 1'b0, 1'b0, 1'b0, 8'h04, 3'd4, 1'b1, 4'b0010, 1'b1);
      #1;
      reset = 1'b1;
      #1;
      check("sdr_abort_dmem_write", 64'(bus.dmem_write), 64'(0));
      check("sdr_abort_state", 64'(state_dbg), 64'(0));
      check("sdr_abort_retired", 64'(retired), 64'(0));
      @(negedge clk);
      reset   = 1'b0;
      exp_ret = '0;
      run_instr(5, 0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
